i2s_iq_tdm_port: RTL and testbench
==================================

Name: i2s_iq_tdm_port

Overview:
- Parametrised I2S/TDM master transceiver that carries multi-channel Tx/Rx IQ samples between the core clock domain and the SDR-3 codec-side serial link.
- Generates CBCLK and CLRCIO by dividing AD9866clk.
- Serialises Tx frames from a small frame FIFO onto CDIN and deserialises CDOUT into Rx frames.
- Extends the fixed 2-channel, 3.072 MHz/48 kHz link to any sample width, slot width, channel count and sync mode, and adds underrun signalling.

Parameters:
- SAMPLE_W, 24: bits per channel sample; must be <= SLOT_W.
- SLOT_W, 32: BCLK periods per slot.
- NCH, 2: slots (channels) per frame; channel 0 = I, channel 1 = Q, and so on.
- MODE, 0: 0 = I2S (NCH must be 2, CLRCIO is LR clock); 1 = TDM (CLRCIO is a one-bit frame-sync pulse).
- BCLK_HALF, 12: AD9866clk cycles per BCLK half-period; must be >= 4. At 73.728 MHz this gives 3.072 MHz BCLK and a 48 kHz frame.
- TX_DEPTH, 4: Tx FIFO depth in frames; power of 2, >= 2.

Ports:
- AD9866clk, in, 1: sole clock.
- extreset, in, 1: asynchronous active-low reset.
- en, in, 1: link enable.
- tx_data, in, NCH*SAMPLE_W: channel k occupies bits [(k+1)*SAMPLE_W-1 : k*SAMPLE_W].
- tx_valid, in, 1: Tx frame valid.
- tx_ready, out, 1: FIFO not full.
- tx_level, out, clog2(TX_DEPTH)+1: FIFO occupancy in frames.
- tx_underrun, out, 1: one-cycle pulse.
- rx_data, out, NCH*SAMPLE_W: same channel packing as tx_data.
- rx_valid, out, 1: one-cycle strobe.
- CBCLK, out, 1: bit clock.
- CLRCIO, out, 1: LR clock (MODE 0) or frame sync (MODE 1).
- CDIN, out, 1: serial data to codec.
- CDOUT, in, 1: serial data from codec; asynchronous.

Behaviour:
- Reset values: CBCLK=0, CLRCIO=0, CDIN=0, tx_ready=1, tx_level=0, tx_underrun=0, rx_data=0, rx_valid=0.
- Reset state: FIFO empty, bit index b=FB-1 (FB=NCH*SLOT_W), divider=0, BCLK phase=high.
- Divider: while en=1, counts 0..BCLK_HALF-1. At terminal count the phase toggles.
  - High->low is a falling tick.
  - Low->high is a rising tick.
- Startup after enable: CBCLK is held 0 until the first falling tick, so the first visible edge is a rising edge with b=0.
- Falling tick:
  - b advances (FB-1 wraps to 0); CDIN and CLRCIO update in the same cycle.
  - Entering b=0:
    - FIFO non-empty: pop one frame into the Tx shift register.
    - FIFO empty: load all zeros and pulse tx_underrun for one cycle.
- CDIN at bit b: slot s=b/SLOT_W, position p=b%SLOT_W.
  - p<SAMPLE_W: outputs channel s bit (SAMPLE_W-1-p), MSB first.
  - Otherwise outputs 0.
- CLRCIO, MODE 0: 1 for SLOT_W-1 <= b < FB-1, else 0. Each edge leads its slot MSB by one BCLK (Philips I2S).
- CLRCIO, MODE 1: 1 only at b=FB-1.
- CDOUT input path: 2-FF synchroniser.
- Rising tick: for p<SAMPLE_W, the synchronised bit shifts into channel s; other positions are ignored.
- Rx output: on the rising tick at b=FB-1, rx_data updates with the full frame and rx_valid pulses for one cycle, same cycle. There is no backpressure.
- Tx FIFO:
  - Push when tx_valid & tx_ready.
  - tx_ready = (level < TX_DEPTH).
  - Simultaneous push and pop: level unchanged.
  - A push in the same cycle as a b=0 load into an empty FIFO is not bypassed: underrun still flagged, the frame is sent next frame.
  - tx_level updates the cycle after push/pop.
- en=0, at any time including mid-frame, from the next cycle:
  - CBCLK, CLRCIO and CDIN are forced 0.
  - Divider and b return to reset state.
  - Shift registers are cleared; the partial Rx frame is discarded with no rx_valid.
  - The Tx frame in flight is discarded; FIFO contents and pushes are retained.
- extreset asserted mid-operation: everything returns to reset values immediately, FIFO flushed.
- Latencies:
  - en rise to first CBCLK rising edge: 2*BCLK_HALF cycles.
  - Frame period: 2*BCLK_HALF*FB cycles (1536 at defaults).

Test Plan:
- Defaults, en=1, no pushes:
  - CBCLK period 24 clocks; CLRCIO period 1536 clocks, high 32 BCLK.
  - CDIN stays 0; tx_underrun pulses once per 1536 clocks.
- Defaults, push I=24'hA5A5A5, Q=24'h3C3C3C, CDIN looped to CDOUT:
  - Serial stream is MSB first with 8 zero-pad bits per slot.
  - rx_data = {24'h3C3C3C, 24'hA5A5A5} with one rx_valid; CLRCIO edges lead each MSB by one BCLK.
- Push 5 frames back-to-back with en=0:
  - tx_ready drops after 4 pushes; tx_level=4; the 5th frame is held off.
  - Enabling drains the FIFO in order, one frame per 1536 clocks.
- MODE=1, NCH=4, SLOT_W=16, SAMPLE_W=16, BCLK_HALF=6:
  - CLRCIO is a one-BCLK pulse every 64 BCLK, at the last bit of each frame.
  - Four channels round-trip via loopback.
- Deassert en at b=40:
  - All outputs 0 on the next cycle; no rx_valid.
  - On re-enable the first frame starts at slot 0 with the next FIFO frame.
- Assert extreset mid-frame with 3 frames queued: tx_level=0, tx_ready=1, all outputs 0 on the same cycle.

Source files
------------

// File: rtl/i2s_iq_tdm_port.sv
// I2S/TDM master transceiver: divides AD9866clk into CBCLK/CLRCIO, serialises
// queued Tx IQ frames onto CDIN and assembles Rx IQ frames from CDOUT.
module i2s_iq_tdm_port #(
  parameter int SAMPLE_W  = 24,
  parameter int SLOT_W    = 32,
  parameter int NCH       = 2,
  parameter int MODE      = 0,
  parameter int BCLK_HALF = 12,
  parameter int TX_DEPTH  = 4
) (
  input  logic                         AD9866clk,
  input  logic                         extreset,
  input  logic                         en,
  input  logic [NCH*SAMPLE_W-1:0]      tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic [$clog2(TX_DEPTH):0]    tx_level,
  output logic                         tx_underrun,
  output logic [NCH*SAMPLE_W-1:0]      rx_data,
  output logic                         rx_valid,
  output logic                         CBCLK,
  output logic                         CLRCIO,
  output logic                         CDIN,
  input  logic                         CDOUT
);
  localparam int FW = NCH*SAMPLE_W;
  localparam int DW = $clog2(BCLK_HALF);
  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam int AW = $clog2(TX_DEPTH);
  localparam logic [DW-1:0] D_LAST   = DW'(BCLK_HALF-1);
  localparam logic [SW-1:0] S_LAST   = SW'(NCH-1);
  localparam logic [PW-1:0] P_LAST   = PW'(SLOT_W-1);
  localparam logic [PW:0]   SAMP_LIM = (PW+1)'(SAMPLE_W);

  // Shift registers hold channel 0 at the top so bits leave/arrive MSB-first in slot order.
  function automatic logic [FW-1:0] swap_ch(input logic [FW-1:0] d);
    logic [FW-1:0] o;
    o = '0;
    for (int k = 0; k < NCH; k++) o[(NCH-1-k)*SAMPLE_W +: SAMPLE_W] = d[k*SAMPLE_W +: SAMPLE_W];
    return o;
  endfunction

  function automatic logic in_sample(input logic [PW-1:0] p);
    return {1'b0, p} < SAMP_LIM;
  endfunction

  logic [DW-1:0] div;
  logic          phase;
  logic [SW-1:0] slot, slot_n;
  logic [PW-1:0] pos, pos_n;
  logic          tick, fall, rise, last, lrc_n;
  logic          cbclk_q, clrc_q, cdin_q, underrun_q, rx_valid_q;
  logic [FW-1:0] txsr, tx_src, rxsr, rx_nxt, rx_data_q;
  logic          din_m, din_s;

  logic [FW-1:0] mem [TX_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic          empty, push, pop;

  assign tick  = en && (div == D_LAST);
  assign fall  = tick & phase;
  assign rise  = tick & ~phase;
  assign last  = (slot == S_LAST) && (pos == P_LAST);
  assign empty = (level == '0);
  assign tx_ready = ~level[AW];
  assign push  = tx_valid & tx_ready;
  assign pop   = fall & last & ~empty;

  always_comb begin
    pos_n  = pos + 1'b1;
    slot_n = slot;
    if (pos == P_LAST) begin
      pos_n  = '0;
      slot_n = (slot == S_LAST) ? '0 : slot + 1'b1;
    end
    if (MODE == 0) lrc_n = ((slot_n != '0) || (pos_n == P_LAST)) && !((slot_n == S_LAST) && (pos_n == P_LAST));
    else           lrc_n = (slot_n == S_LAST) && (pos_n == P_LAST);
  end

  // Frame load happens on the falling tick that enters bit 0; an empty FIFO sends silence.
  always_comb begin
    tx_src = txsr;
    if (last) tx_src = empty ? '0 : swap_ch(mem[rd_ptr]);
    rx_nxt = in_sample(pos) ? {rxsr[FW-2:0], din_s} : rxsr;
  end

  always_ff @(posedge AD9866clk or negedge extreset) begin
    if (!extreset) begin
      din_m <= 1'b0;
      din_s <= 1'b0;
    end else begin
      din_m <= CDOUT;
      din_s <= din_m;
    end
  end

  always_ff @(posedge AD9866clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge AD9866clk or negedge extreset) begin
    if (!extreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge AD9866clk or negedge extreset) begin
    if (!extreset) begin
      div <= '0; phase <= 1'b1; slot <= S_LAST; pos <= P_LAST;
      cbclk_q <= 1'b0; clrc_q <= 1'b0; cdin_q <= 1'b0;
      txsr <= '0; rxsr <= '0; rx_data_q <= '0;
      rx_valid_q <= 1'b0; underrun_q <= 1'b0;
    end else if (!en) begin
      div <= '0; phase <= 1'b1; slot <= S_LAST; pos <= P_LAST;
      cbclk_q <= 1'b0; clrc_q <= 1'b0; cdin_q <= 1'b0;
      txsr <= '0; rxsr <= '0;
      rx_valid_q <= 1'b0; underrun_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      div <= (div == D_LAST) ? '0 : div + 1'b1;
      if (tick) phase <= ~phase;
      if (fall) begin
        cbclk_q    <= 1'b0;
        slot       <= slot_n;
        pos        <= pos_n;
        clrc_q     <= lrc_n;
        underrun_q <= last & empty;
        if (in_sample(pos_n)) {cdin_q, txsr} <= {tx_src, 1'b0};
        else begin
          cdin_q <= 1'b0;
          txsr   <= tx_src;
        end
      end
      if (rise) begin
        cbclk_q <= 1'b1;
        rxsr    <= rx_nxt;
        if (last) begin
          rx_data_q  <= swap_ch(rx_nxt);
          rx_valid_q <= 1'b1;
        end
      end
    end
  end

  assign tx_level    = level;
  assign tx_underrun = underrun_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign CBCLK       = cbclk_q;
  assign CLRCIO      = clrc_q;
  assign CDIN        = cdin_q;
endmodule

// File: tb/tb_i2s_iq_tdm_port.sv
// Directed bench: I2S default instance with CDIN looped to CDOUT, plus a 4-channel TDM instance.
module tb_i2s_iq_tdm_port;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en0, en1, txv0, txv1;
  logic [47:0] txd0;
  logic [63:0] txd1;
  logic        rdy0, und0, rxv0, cb0, lr0, cdin0;
  logic        rdy1, und1, rxv1, cb1, lr1, cdin1;
  logic [2:0]  lvl0, lvl1;
  logic [47:0] rxd0;
  logic [63:0] rxd1;

  int errors = 0;
  int checks = 0;

  i2s_iq_tdm_port u0 (
    .AD9866clk(clk), .extreset(rst_n), .en(en0),
    .tx_data(txd0), .tx_valid(txv0), .tx_ready(rdy0), .tx_level(lvl0), .tx_underrun(und0),
    .rx_data(rxd0), .rx_valid(rxv0),
    .CBCLK(cb0), .CLRCIO(lr0), .CDIN(cdin0), .CDOUT(cdin0)
  );

  i2s_iq_tdm_port #(.SAMPLE_W(16), .SLOT_W(16), .NCH(4), .MODE(1), .BCLK_HALF(6)) u1 (
    .AD9866clk(clk), .extreset(rst_n), .en(en1),
    .tx_data(txd1), .tx_valid(txv1), .tx_ready(rdy1), .tx_level(lvl1), .tx_underrun(und1),
    .rx_data(rxd1), .rx_valid(rxv1),
    .CBCLK(cb1), .CLRCIO(lr1), .CDIN(cdin1), .CDOUT(cdin1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps through one frame, sampling CDIN/CLRCIO/CBCLK at each rising BCLK and CBCLK at each fall.
  task automatic run_frame(input bit tdm, input bit do_push, input logic [47:0] pd,
                           output logic [63:0] dw, output logic [63:0] lw,
                           output logic [63:0] hi, output logic [63:0] lo,
                           output int rv, output int un);
    int half;
    half = tdm ? 6 : 12;
    dw = '0; lw = '0; hi = '0; lo = '0; rv = 0; un = 0;
    for (int k = 0; k < 64; k++) begin
      for (int j = 1; j <= 2*half; j++) begin
        step();
        rv += int'(tdm ? rxv1 : rxv0);
        un += int'(tdm ? und1 : und0);
        if (do_push && k == 0 && j == half-1) begin txd0 = pd; txv0 = 1'b1; end
        if (do_push && k == 0 && j == half) txv0 = 1'b0;
        if (j == half) lo[63-k] = tdm ? cb1 : cb0;
      end
      hi[63-k] = tdm ? cb1 : cb0;
      dw[63-k] = tdm ? cdin1 : cdin0;
      lw[63-k] = tdm ? lr1 : lr0;
    end
  endtask

  logic [47:0] fr [6];
  logic [63:0] dw, lw, hi, lo;
  int rv, un;

  initial begin
    fr[0] = {24'h3C3C3C, 24'hA5A5A5};
    fr[1] = {24'hFFFFFF, 24'h123456};
    fr[2] = {24'h0F0F0F, 24'h800001};
    fr[3] = {24'h654321, 24'hFEDCBA};
    fr[4] = {24'h222222, 24'h111111};
    fr[5] = {24'hBADBAD, 24'hC0FFEE};
    rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0; txv0 = 1'b0; txv1 = 1'b0; txd0 = '0; txd1 = '0;
    repeat (3) step();
    chk("rst_cbclk", 64'(cb0), 64'd0);
    chk("rst_clrcio", 64'(lr0), 64'd0);
    chk("rst_cdin", 64'(cdin0), 64'd0);
    chk("rst_ready", 64'(rdy0), 64'd1);
    chk("rst_level", 64'(lvl0), 64'd0);
    chk("rst_underrun", 64'(und0), 64'd0);
    chk("rst_rxdata", 64'(rxd0), 64'd0);
    chk("rst_rxvalid", 64'(rxv0), 64'd0);
    rst_n = 1'b1;
    step();

    // Five back-to-back pushes with the link idle: the fifth is held off.
    for (int i = 0; i < 5; i++) begin
      txd0 = fr[i]; txv0 = 1'b1;
      step();
      if (i == 2) begin
        chk("fill_level3", 64'(lvl0), 64'd3);
        chk("fill_ready3", 64'(rdy0), 64'd1);
      end
    end
    txv0 = 1'b0;
    step();
    chk("full_level", 64'(lvl0), 64'd4);
    chk("full_ready", 64'(rdy0), 64'd0);

    en0 = 1'b1;
    run_frame(1'b0, 1'b0, '0, dw, lw, hi, lo, rv, un);
    chk("f0_cdin", dw, 64'hA5A5A5003C3C3C00);
    chk("f0_clrcio", lw, 64'h00000001FFFFFFFE);
    chk("f0_bclk_hi", hi, '1);
    chk("f0_bclk_lo", lo, '0);
    chk("f0_rxvalid", 64'(rv), 64'd1);
    chk("f0_underrun", 64'(un), 64'd0);
    chk("f0_rxdata", 64'(rxd0), {16'h0, 24'h3C3C3C, 24'hA5A5A5});
    chk("f0_level", 64'(lvl0), 64'd3);

    // Next frame: stop at the rising edge of bit 40 and drop enable.
    repeat (984) step();
    chk("b40_cbclk", 64'(cb0), 64'd1);
    chk("b40_clrcio", 64'(lr0), 64'd1);
    chk("b40_cdin", 64'(cdin0), 64'd1);
    chk("b40_level", 64'(lvl0), 64'd2);
    en0 = 1'b0;
    step();
    chk("off_outputs", 64'({cb0, lr0, cdin0}), 64'd0);
    rv = 0;
    repeat (1600) begin step(); rv += int'(rxv0); end
    chk("off_rxvalid", 64'(rv), 64'd0);
    chk("off_level", 64'(lvl0), 64'd2);

    en0 = 1'b1;
    run_frame(1'b0, 1'b0, '0, dw, lw, hi, lo, rv, un);
    chk("f2_cdin", dw, 64'h800001000F0F0F00);
    chk("f2_rxdata", 64'(rxd0), {16'h0, 24'h0F0F0F, 24'h800001});
    chk("f2_rxvalid", 64'(rv), 64'd1);
    chk("f2_level", 64'(lvl0), 64'd1);

    run_frame(1'b0, 1'b0, '0, dw, lw, hi, lo, rv, un);
    chk("f3_cdin", dw, 64'hFEDCBA0065432100);
    chk("f3_rxdata", 64'(rxd0), {16'h0, 24'h654321, 24'hFEDCBA});
    chk("f3_underrun", 64'(un), 64'd0);
    chk("f3_level", 64'(lvl0), 64'd0);

    // Empty FIFO at the load, with a push landing in that same cycle.
    run_frame(1'b0, 1'b1, fr[5], dw, lw, hi, lo, rv, un);
    chk("ur_cdin", dw, 64'd0);
    chk("ur_underrun", 64'(un), 64'd1);
    chk("ur_rxvalid", 64'(rv), 64'd1);
    chk("ur_rxdata", 64'(rxd0), 64'd0);
    chk("ur_level", 64'(lvl0), 64'd1);

    run_frame(1'b0, 1'b0, '0, dw, lw, hi, lo, rv, un);
    chk("f5_cdin", dw, 64'hC0FFEE00BADBAD00);
    chk("f5_underrun", 64'(un), 64'd0);
    chk("f5_rxdata", 64'(rxd0), {16'h0, 24'hBADBAD, 24'hC0FFEE});

    // Queue frames, run to mid-frame, then pull reset asynchronously.
    for (int i = 0; i < 4; i++) begin
      txd0 = fr[i]; txv0 = 1'b1;
      step();
    end
    txv0 = 1'b0;
    repeat (980) step();
    chk("pre_rst_cbclk", 64'(cb0), 64'd1);
    chk("pre_rst_clrcio", 64'(lr0), 64'd1);
    chk("pre_rst_level", 64'(lvl0), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_level", 64'(lvl0), 64'd0);
    chk("arst_ready", 64'(rdy0), 64'd1);
    chk("arst_outputs", 64'({cb0, lr0, cdin0}), 64'd0);
    chk("arst_rxdata", 64'(rxd0), 64'd0);
    en0 = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Four-channel TDM instance, frame sync at the last bit.
    txd1 = 64'h0F0FFFFF12348001; txv1 = 1'b1;
    step();
    txv1 = 1'b0;
    chk("tdm_level", 64'(lvl1), 64'd1);
    en1 = 1'b1;
    run_frame(1'b1, 1'b0, '0, dw, lw, hi, lo, rv, un);
    chk("tdm_cdin", dw, 64'h80011234FFFF0F0F);
    chk("tdm_fsync", lw, 64'h1);
    chk("tdm_bclk_hi", hi, '1);
    chk("tdm_bclk_lo", lo, '0);
    chk("tdm_rxvalid", 64'(rv), 64'd1);
    chk("tdm_underrun", 64'(un), 64'd0);
    chk("tdm_rxdata", rxd1, 64'h0F0FFFFF12348001);
    chk("tdm_level_end", 64'(lvl1), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
